// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
// Optional perf counters are enabled with MEM_ARB_PERF_EN.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int PERF_W     = 16;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef enum logic {
    RR_IF = 1'b0,
    RR_LS = 1'b1
  } rr_e;

  function automatic logic [PERF_W-1:0] sat_inc(
    input logic [PERF_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant for IF/LS requesters.
// The pointer only moves on a conflict grant.
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter bit LS_FIRST = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic if_req,
  input  logic ls_req,
  output logic if_gnt,
  output logic ls_gnt
);

  rr_e  rr_q;
  rr_e  rr_d;
  logic conflict;

  assign conflict = if_req & ls_req;

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    rr_d   = rr_q;
    unique case (1'b1)
      conflict: begin
        ls_gnt = (rr_q == RR_LS);
        if_gnt = (rr_q == RR_IF);
        rr_d   = (rr_q == RR_LS) ? RR_IF : RR_LS;
      end
      ls_req & ~if_req: ls_gnt = 1'b1;
      if_req & ~ls_req: if_gnt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rr_q <= rr_e'(LS_FIRST);
    else     rr_q <= rr_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// IF/LS front end for the single-port SRAM: arbitration, address stage,
// registered read return. Define MEM_ARB_PERF_EN for the perf counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit LS_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       perf_conf,
  output logic [15:0]       perf_acc
);

  logic              acc;
  logic              v_q;
  logic              we_q;
  logic              own_q;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] din_q;
  logic              rd_hit;
  logic              rv_q;
  logic              rown_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  mem_arb_rr #(
    .LS_FIRST (LS_FIRST)
  ) u_rr (
    .CLK    (CLK),
    .RST    (RST),
    .if_req (if_req),
    .ls_req (ls_req),
    .if_gnt (if_gnt),
    .ls_gnt (ls_gnt)
  );

  assign acc = if_gnt | ls_gnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_q   <= 1'b0;
      we_q  <= 1'b0;
      own_q <= OWN_IF;
      a_q   <= '0;
      din_q <= '0;
    end else begin
      v_q  <= acc;
      we_q <= ls_gnt & ls_we;
      if (acc) begin
        own_q <= ls_gnt ? OWN_LS : OWN_IF;
        a_q   <= ls_gnt ? ls_addr : if_addr;
      end
      if (ls_gnt) din_q <= ls_wdata;
    end
  end

  assign mem_a   = a_q;
  assign mem_din = din_q;
  assign mem_we  = v_q & we_q;

  // Separate per-owner data regs so each rdata holds across the other's returns
  assign rd_hit = v_q & ~we_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rv_q       <= 1'b0;
      rown_q     <= OWN_IF;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      rv_q   <= rd_hit;
      rown_q <= own_q;
      if (rd_hit && own_q == OWN_IF) if_rdata_q <= mem_dout;
      if (rd_hit && own_q == OWN_LS) ls_rdata_q <= mem_dout;
    end
  end

  assign if_rvalid = rv_q & (rown_q == OWN_IF);
  assign ls_rvalid = rv_q & (rown_q == OWN_LS);
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [PERF_W-1:0] conf_q;
  logic [PERF_W-1:0] acc_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      conf_q <= '0;
      acc_q  <= '0;
    end else begin
      if (if_req & ls_req) conf_q <= sat_inc(conf_q);
      if (acc)             acc_q  <= sat_inc(acc_q);
    end
  end

  assign perf_conf = conf_q;
  assign perf_acc  = acc_q;
`else
  assign perf_conf = '0;
  assign perf_acc  = '0;
`endif

endmodule
